icache_refill_ctrl: RTL and testbench



---
 rtl/icache_refill_ctrl_pkg.sv | 19 +
 rtl/icache_refill_line_buffer.sv | 46 ++++
 rtl/icache_refill_ctrl.sv | 117 +++++++++++
 tb/tb_icache_refill_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_refill_ctrl_pkg.sv
// rtl/icache_refill_ctrl_pkg.sv - shared core constants and the refill FSM state type
`ifndef MEMORY_WORD
`define MEMORY_WORD 32
`endif
`ifndef PC_SIZE
`define PC_SIZE 32
`endif

package constants;
  localparam int MEM_W          = `MEMORY_WORD;
  localparam int PC_W           = `PC_SIZE;
  localparam int LINE_WORDS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FILL    = 2'd2
  } refill_state_t;
endpackage

// File: rtl/icache_refill_line_buffer.sv
// rtl/icache_refill_line_buffer.sv - line assembly registers with an indexed write port and flat line output
module refill_line_buffer
  import constants::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int WORD_W     = MEM_W,
  parameter int IDX_W      = $clog2(LINE_WORDS)
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         we,
  input  logic [IDX_W-1:0]             widx,
  input  logic [WORD_W-1:0]            wdata,
  output logic [LINE_WORDS*WORD_W-1:0] line
);
  logic [WORD_W-1:0] slot_q [LINE_WORDS];
  logic [WORD_W-1:0] slot_d [LINE_WORDS];

  always_comb begin
    for (int k = 0; k < LINE_WORDS; k++) begin
      slot_d[k] = slot_q[k];
    end
    if (we) begin
      slot_d[widx] = wdata;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int k = 0; k < LINE_WORDS; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < LINE_WORDS; k++) begin
        slot_q[k] <= slot_d[k];
      end
    end
  end

  always_comb begin
    line = '0;
    for (int k = 0; k < LINE_WORDS; k++) begin
      line[k*WORD_W +: WORD_W] = slot_q[k];
    end
  end
endmodule

// File: rtl/icache_refill_ctrl.sv
// rtl/icache_refill_ctrl.sv - I-cache miss refill: collects a line from memory, forwards the critical word, fills the arrays
module icache_refill_ctrl
  import constants::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int OFF_BITS   = $clog2(LINE_WORDS)
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic                        miss_req,
  input  logic [PC_W-1:0]             miss_addr,
  output logic                        refill_busy,
  output logic                        i_miss,
  output logic [PC_W-1:0]             ram_address,
  input  logic                        word_ready,
  input  logic [MEM_W-1:0]            mem_word,
  output logic                        crit_valid,
  output logic [MEM_W-1:0]            crit_word,
  output logic                        fill_we,
  output logic [PC_W-1:0]             fill_addr,
  output logic [LINE_WORDS*MEM_W-1:0] fill_line
);
  localparam logic [PC_W-1:0]     OFF_MASK = PC_W'(LINE_WORDS - 1);
  localparam logic [OFF_BITS-1:0] LAST_IDX = OFF_BITS'(LINE_WORDS - 1);

  refill_state_t       state_q, state_d;
  logic [OFF_BITS-1:0] cnt_q, cnt_d;
  logic [OFF_BITS-1:0] crit_idx_q, crit_idx_d;
  logic [PC_W-1:0]     ram_address_q, ram_address_d;
  logic [PC_W-1:0]     fill_addr_q, fill_addr_d;
  logic                i_miss_q, i_miss_d;
  logic                refill_busy_q, refill_busy_d;
  logic                fill_we_q, fill_we_d;
  logic                buf_we;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    crit_idx_d    = crit_idx_q;
    ram_address_d = ram_address_q;
    fill_addr_d   = fill_addr_q;
    buf_we        = 1'b0;

    case (state_q)
      IDLE: begin
        if (miss_req) begin
          state_d       = COLLECT;
          cnt_d         = '0;
          crit_idx_d    = miss_addr[OFF_BITS+1:2];
          ram_address_d = (miss_addr >> 2) & ~OFF_MASK;
          fill_addr_d   = miss_addr & ~((OFF_MASK << 2) | PC_W'(3));
        end
      end
      COLLECT: begin
        if (word_ready) begin
          buf_we = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) begin
            state_d = FILL;
          end
        end
      end
      FILL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Status outputs are registered from the next state so they line up with it.
    i_miss_d      = (state_d == COLLECT);
    refill_busy_d = (state_d != IDLE);
    fill_we_d     = (state_d == FILL);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      crit_idx_q    <= '0;
      ram_address_q <= '0;
      fill_addr_q   <= '0;
      i_miss_q      <= 1'b0;
      refill_busy_q <= 1'b0;
      fill_we_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      crit_idx_q    <= crit_idx_d;
      ram_address_q <= ram_address_d;
      fill_addr_q   <= fill_addr_d;
      i_miss_q      <= i_miss_d;
      refill_busy_q <= refill_busy_d;
      fill_we_q     <= fill_we_d;
    end
  end

  refill_line_buffer #(
    .LINE_WORDS (LINE_WORDS),
    .WORD_W     (MEM_W),
    .IDX_W      (OFF_BITS)
  ) u_line_buffer (
    .clk   (clk),
    .nrst  (nrst),
    .we    (buf_we),
    .widx  (cnt_q),
    .wdata (mem_word),
    .line  (fill_line)
  );

  // Critical word bypasses the buffer so fetch can restart before the fill.
  assign crit_valid  = (state_q == COLLECT) && word_ready && (cnt_q == crit_idx_q);
  assign crit_word   = mem_word;

  assign i_miss      = i_miss_q;
  assign refill_busy = refill_busy_q;
  assign ram_address = ram_address_q;
  assign fill_we     = fill_we_q;
  assign fill_addr   = fill_addr_q;
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb/tb_icache_refill_ctrl.sv - scoreboard bench for icache_refill_ctrl with a line-level memory model
module tb_icache_refill_ctrl;
  import constants::*;

  localparam int LW     = 4;
  localparam int LINE_W = LW * MEM_W;

  logic              clk = 1'b0;
  logic              nrst;
  logic              miss_req;
  logic [PC_W-1:0]   miss_addr;
  logic              refill_busy;
  logic              i_miss;
  logic [PC_W-1:0]   ram_address;
  logic              word_ready;
  logic [MEM_W-1:0]  mem_word;
  logic              crit_valid;
  logic [MEM_W-1:0]  crit_word;
  logic              fill_we;
  logic [PC_W-1:0]   fill_addr;
  logic [LINE_W-1:0] fill_line;

  typedef struct {
    logic [PC_W-1:0]   addr;
    logic [LINE_W-1:0] line;
  } fill_t;

  fill_t            fill_q[$];
  logic [MEM_W-1:0] crit_q[$];
  logic [PC_W-1:0]  ram_q[$];
  logic [MEM_W-1:0] ram [256];

  int n_checks = 0;
  int n_fail   = 0;

  fill_t fe;
  bit    prev_miss = 1'b0;
  bit    seen_fall = 1'b0;
  int    low_cnt   = 0;

  icache_refill_ctrl #(.LINE_WORDS(LW)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .miss_req    (miss_req),
    .miss_addr   (miss_addr),
    .refill_busy (refill_busy),
    .i_miss      (i_miss),
    .ram_address (ram_address),
    .word_ready  (word_ready),
    .mem_word    (mem_word),
    .crit_valid  (crit_valid),
    .crit_word   (crit_word),
    .fill_we     (fill_we),
    .fill_addr   (fill_addr),
    .fill_line   (fill_line)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: DUT output with no pending expectation", name);
  endtask

  // Reference model: a line is LW consecutive words starting at the word address rounded down to a line.
  function automatic int word_base(input logic [PC_W-1:0] a);
    int w;
    w = int'(a / 4);
    return w - (w % LW);
  endfunction

  function automatic logic [LINE_W-1:0] model_line(input logic [PC_W-1:0] a);
    logic [LINE_W-1:0] l;
    l = '0;
    for (int k = 0; k < LW; k++) l[k*MEM_W +: MEM_W] = ram[word_base(a) + k];
    return l;
  endfunction

  task automatic expect_refill(input logic [PC_W-1:0] a);
    fill_t f;
    f.addr = a - (a % PC_W'(4 * LW));
    f.line = model_line(a);
    ram_q.push_back(PC_W'(word_base(a)));
    crit_q.push_back(ram[int'(a / 4)]);
    fill_q.push_back(f);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Acts as the cache (holds miss_req) and as memory (serves words from ram_address upward).
  task automatic refill(input logic [PC_W-1:0] addr, input int gfix, input int gmax, input int abort_after,
                        input bit chain, input logic [PC_W-1:0] next_addr, input bit spur);
    int budget;
    int gap;
    int crit;
    crit = int'(addr / 4) % LW;
    expect_refill(addr);
    miss_req  = 1'b1;
    miss_addr = addr;
    cyc();
    budget = 0;
    while (!i_miss && budget < 8) begin
      cyc();
      budget++;
    end
    check("miss_latency", LINE_W'(budget), LINE_W'(0));
    check("busy_on_miss", LINE_W'(refill_busy), LINE_W'(1));
    for (int k = 0; k < LW; k++) begin
      if (k == abort_after) begin
        word_ready = 1'b0;
        miss_req   = 1'b0;
        nrst       = 1'b0;
        #1;
        check("reset_i_miss", LINE_W'(i_miss), LINE_W'(0));
        check("reset_busy", LINE_W'(refill_busy), LINE_W'(0));
        check("reset_line", fill_line, LINE_W'(0));
        crit_q.delete();
        fill_q.delete();
        cyc();
        cyc();
        check("reset_no_fill", LINE_W'(fill_we), LINE_W'(0));
        nrst = 1'b1;
        cyc();
        return;
      end
      gap = (gfix >= 0) ? gfix : int'($urandom_range(gmax, 0));
      for (int g = 0; g < gap; g++) begin
        word_ready = 1'b0;
        mem_word   = $urandom;
        cyc();
        check("i_miss_hold", LINE_W'(i_miss), LINE_W'(1));
      end
      word_ready = 1'b1;
      mem_word   = ram[int'(ram_address) + k];
      #1;
      check("crit_timing", LINE_W'(crit_valid), LINE_W'(k == crit));
      cyc();
    end
    word_ready = spur;
    mem_word   = $urandom;
    check("fill_we_rise", LINE_W'(fill_we), LINE_W'(1));
    check("i_miss_fall", LINE_W'(i_miss), LINE_W'(0));
    cyc();
    check("fill_we_once", LINE_W'(fill_we), LINE_W'(0));
    check("busy_idle", LINE_W'(refill_busy), LINE_W'(0));
    word_ready = 1'b0;
    if (chain) miss_addr = next_addr;
    else miss_req = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a critical word, a fill or a new request.
  initial begin
    forever begin
      @(negedge clk);
      if (crit_valid) begin
        if (crit_q.size() == 0) flag("crit_unexpected");
        else check("crit_word", LINE_W'(crit_word), LINE_W'(crit_q.pop_front()));
      end
      if (fill_we) begin
        if (fill_q.size() == 0) flag("fill_unexpected");
        else begin
          fe = fill_q.pop_front();
          check("fill_addr", LINE_W'(fill_addr), LINE_W'(fe.addr));
          check("fill_line", fill_line, fe.line);
        end
      end
      if (i_miss && !prev_miss) begin
        if (ram_q.size() == 0) flag("miss_unexpected");
        else check("ram_address", LINE_W'(ram_address), LINE_W'(ram_q.pop_front()));
        if (seen_fall) check("miss_gap", LINE_W'(low_cnt >= 2), LINE_W'(1));
      end
      if (!i_miss && prev_miss) begin
        seen_fall = 1'b1;
        low_cnt   = 0;
      end
      if (!i_miss) low_cnt++;
      prev_miss = i_miss;
    end
  end

  initial begin
    logic [PC_W-1:0]   cur;
    logic [PC_W-1:0]   nxt;
    logic [LINE_W-1:0] held;
    bit                ch;

    for (int i = 0; i < 256; i++) ram[i] = $urandom;
    for (int k = 0; k < 4; k++) ram[16 + k] = MEM_W'(32'hA0 + k);

    nrst       = 1'b0;
    miss_req   = 1'b0;
    miss_addr  = '0;
    word_ready = 1'b0;
    mem_word   = '0;
    cyc();
    cyc();
    check("rst_i_miss", LINE_W'(i_miss), LINE_W'(0));
    check("rst_busy", LINE_W'(refill_busy), LINE_W'(0));
    check("rst_fill_we", LINE_W'(fill_we), LINE_W'(0));
    check("rst_crit_valid", LINE_W'(crit_valid), LINE_W'(0));
    check("rst_ram_address", LINE_W'(ram_address), LINE_W'(0));
    check("rst_fill_addr", LINE_W'(fill_addr), LINE_W'(0));
    check("rst_fill_line", fill_line, LINE_W'(0));
    nrst = 1'b1;
    cyc();

    // Basic refill, every other cycle; then fixed gaps of 0, 3 and 7 on the same line.
    refill(32'h48, 1, 0, LW, 1'b0, '0, 1'b0);
    check("basic_line_const", fill_line, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    refill(32'h48, 0, 0, LW, 1'b0, '0, 1'b0);
    cyc();
    refill(32'h48, 3, 0, LW, 1'b0, '0, 1'b0);
    cyc();
    refill(32'h48, 7, 0, LW, 1'b0, '0, 1'b0);
    cyc();

    // Spurious word_ready in IDLE before and after a refill, and during FILL.
    for (int i = 0; i < 3; i++) begin
      word_ready = 1'b1;
      mem_word   = $urandom;
      cyc();
    end
    word_ready = 1'b0;
    refill(32'h104, -1, 3, LW, 1'b0, '0, 1'b1);
    held = model_line(32'h104);
    for (int i = 0; i < 3; i++) begin
      word_ready = 1'b1;
      mem_word   = $urandom;
      cyc();
    end
    word_ready = 1'b0;
    check("idle_buffer_kept", fill_line, held);

    // Back-to-back misses: 0x40 then 0x80 with miss_req never dropping.
    refill(32'h40, 2, 0, LW, 1'b1, 32'h80, 1'b0);
    refill(32'h80, 1, 0, LW, 1'b0, '0, 1'b0);
    cyc();

    // Reset after two words, then a clean refill of the same line.
    refill(32'h2C, 1, 0, 2, 1'b0, '0, 1'b0);
    refill(32'h2C, 1, 0, LW, 1'b0, '0, 1'b0);
    cyc();

    // Critical word at offset 0.
    refill(32'h40, 2, 0, LW, 1'b0, '0, 1'b0);
    cyc();

    // Randomized refills with random gaps and occasional chaining.
    cur = PC_W'($urandom_range(32'h3FF, 0));
    for (int i = 0; i < 40; i++) begin
      nxt = PC_W'($urandom_range(32'h3FF, 0));
      ch  = (i < 39) && ($urandom_range(2, 0) == 0);
      refill(cur, -1, 4, LW, ch, nxt, 1'b0);
      if (!ch) begin
        repeat ($urandom_range(2, 0)) cyc();
      end
      cur = nxt;
    end

    repeat (4) cyc();
    check("crit_queue_drained", LINE_W'(crit_q.size()), LINE_W'(0));
    check("fill_queue_drained", LINE_W'(fill_q.size()), LINE_W'(0));
    check("ram_queue_drained", LINE_W'(ram_q.size()), LINE_W'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
